// File: rtl/cordic_adder_scheduler.sv
// CORDIC rotation-mode iteration sequencer sharing one external 32-bit adder.
// Ports: clk/rst, start/ready/done handshake, x/y/z in/out, atan ROM idx/val,
// add_a/add_b/add_cin to the shared adder, add_sum/add_cout back from it.
module cordic_adder_scheduler #(
    parameter int N_ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic        ready,
    output logic        done,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic [4:0]  atan_idx,
    input  logic [31:0] atan_val,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XU,
        S_YU,
        S_ZU,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(N_ITER - 1);

    state_t      state_q, state_d;
    logic [4:0]  i_q, i_d;
    logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, xt_q, xt_d;
    logic [31:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

    // Carry-out is deliberately dropped: all arithmetic wraps modulo 2^32.
    logic unused_cout;
    assign unused_cout = add_cout;

    logic        neg;
    logic [31:0] x_sh, y_sh, opb;
    logic        sub;

    assign neg  = z_q[31];
    assign x_sh = $signed(x_q) >>> i_q;
    assign y_sh = $signed(y_q) >>> i_q;

    // Operand select; subtraction is A + ~B + 1 on the shared adder.
    always_comb begin
        add_a = '0;
        opb   = '0;
        sub   = 1'b0;
        unique case (state_q)
            S_XU: begin
                add_a = x_q;
                opb   = y_sh;
                sub   = ~neg;
            end
            S_YU: begin
                add_a = y_q;
                opb   = x_sh;
                sub   = neg;
            end
            S_ZU: begin
                add_a = z_q;
                opb   = atan_val;
                sub   = ~neg;
            end
            default: begin
                add_a = '0;
                opb   = '0;
                sub   = 1'b0;
            end
        endcase
    end

    assign add_b   = sub ? ~opb : opb;
    assign add_cin = sub;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xt_d    = xt_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = z_in;
                    i_d     = '0;
                    state_d = S_XU;
                end
            end
            S_XU: begin
                xt_d    = add_sum;
                state_d = S_YU;
            end
            S_YU: begin
                y_d     = add_sum;
                state_d = S_ZU;
            end
            S_ZU: begin
                z_d = add_sum;
                x_d = xt_q;
                if (i_q == LAST) begin
                    // Publish the post-update values of the final iteration.
                    xo_d    = xt_q;
                    yo_d    = y_q;
                    zo_d    = add_sum;
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 5'd1;
                    state_d = S_XU;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xt_q    <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xt_q    <= xt_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign x_out    = xo_q;
    assign y_out    = yo_q;
    assign z_out    = zo_q;
    assign atan_idx = i_q;

endmodule

// File: tb/tb_cordic_adder_scheduler.sv
// Directed bench for cordic_adder_scheduler with one N_ITER=1 and one
// N_ITER=16 instance, each with a behavioural adder and atan ROM.
module tb_cordic_adder_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start16 = 1'b0;
    logic [31:0] x_in = '0, y_in = '0, z_in = '0;

    logic        rdy1, dn1, ac1, rdy16, dn16, ac16;
    logic [31:0] xo1, yo1, zo1, aa1, ab1, s1, at1;
    logic [31:0] xo16, yo16, zo16, aa16, ab16, s16, at16;
    logic [4:0]  idx1, idx16;
    logic [31:0] rom [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign s1   = aa1 + ab1 + {31'b0, ac1};
    assign s16  = aa16 + ab16 + {31'b0, ac16};
    assign at1  = (idx1 == 5'd0) ? 32'h2000_0000 : 32'h0;
    assign at16 = rom[idx16];

    cordic_adder_scheduler #(.N_ITER(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .ready(rdy1), .done(dn1),
        .x_out(xo1), .y_out(yo1), .z_out(zo1),
        .atan_idx(idx1), .atan_val(at1),
        .add_a(aa1), .add_b(ab1), .add_cin(ac1),
        .add_sum(s1), .add_cout(1'b0)
    );

    cordic_adder_scheduler #(.N_ITER(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .ready(rdy16), .done(dn16),
        .x_out(xo16), .y_out(yo16), .z_out(zo16),
        .atan_idx(idx16), .atan_val(at16),
        .add_a(aa16), .add_b(ab16), .add_cin(ac16),
        .add_sum(s16), .add_cout(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Straight-line CORDIC rotation reference on the bench's own ROM.
    task automatic model(input logic [31:0] x0, y0, z0, input int n,
                         output logic [31:0] xf, yf, zf);
        logic [31:0] x, y, z, xs, ys;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < n; i++) begin
            xs = $signed(x) >>> i;
            ys = $signed(y) >>> i;
            if (!z[31]) begin
                {x, y, z} = {x - ys, y + xs, z - rom[i]};
            end else begin
                {x, y, z} = {x + ys, y - xs, z + rom[i]};
            end
        end
        xf = x; yf = y; zf = z;
    endtask

    // Issue one start, then watch a bounded window for done pulses.
    task automatic run_op(input bit big, input logic [31:0] x, y, z,
                          output int lat, output int pulses,
                          output bit rdy_hi);
        int n;
        n = big ? 16 : 1;
        @(negedge clk);
        x_in = x; y_in = y; z_in = z;
        if (big) start16 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        start1  = 1'b0;
        lat = -1; pulses = 0; rdy_hi = 1'b0;
        for (int k = 1; k <= 3 * n + 4; k++) begin
            if (big && k == 10) start16 = 1'b1;
            if (big && k == 12) start16 = 1'b0;
            @(posedge clk);
            #1;
            if (big ? dn16 : dn1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k <= 3 * n && (big ? rdy16 : rdy1)) rdy_hi = 1'b1;
        end
    endtask

    initial begin
        int lat, pulses;
        bit rdy_hi;
        logic [31:0] ex, ey, ez, dx, dy;

        for (int i = 0; i < 32; i++)
            rom[i] = 32'($rtoi($atan(1.0 / (2.0 ** i)) * 268435456.0 + 0.5));

        #1;
        check("rst_ready", {31'b0, rdy16}, 32'd1);
        check("rst_done", {31'b0, dn16}, 32'd0);
        check("rst_xout", xo16, 32'h0);
        check("rst_adda", aa16, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 32'h100, 32'h0, 32'h0, lat, pulses, rdy_hi);
        check("pos_lat", lat, 32'd3);
        check("pos_pulses", pulses, 32'd1);
        check("pos_x", xo1, 32'h0000_0100);
        check("pos_y", yo1, 32'h0000_0100);
        check("pos_z", zo1, 32'hE000_0000);

        run_op(1'b0, 32'h100, 32'h0, 32'hF000_0000, lat, pulses, rdy_hi);
        check("neg_x", xo1, 32'h0000_0100);
        check("neg_y", yo1, 32'hFFFF_FF00);
        check("neg_z", zo1, 32'h1000_0000);

        run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, lat, pulses, rdy_hi);
        check("wrap_x", xo1, 32'hFFFF_FFFF);
        check("wrap_y", yo1, 32'hFFFF_FFFF);
        check("wrap_z", zo1, 32'hE000_0000);

        run_op(1'b1, 32'h26DD_3B6A, 32'h0, 32'h0C90_FDAA, lat, pulses, rdy_hi);
        model(32'h26DD_3B6A, 32'h0, 32'h0C90_FDAA, 16, ex, ey, ez);
        check("full_lat", lat, 32'd48);
        check("full_pulses", pulses, 32'd1);
        check("full_busy_ready", {31'b0, rdy_hi}, 32'd0);
        check("full_x", xo16, ex);
        check("full_y", yo16, ey);
        check("full_z", zo16, ez);
        dx = xo16 - 32'h2D41_3CCC;
        dy = yo16 - 32'h2D41_3CCC;
        check("full_x_near", {31'b0, ($signed(dx) <= 65536 && $signed(dx) >= -65536)}, 32'd1);
        check("full_y_near", {31'b0, ($signed(dy) <= 65536 && $signed(dy) >= -65536)}, 32'd1);

        // Asynchronous reset while in the first XU cycle.
        @(negedge clk);
        x_in = 32'h100; y_in = 32'h0; z_in = 32'h0;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        check("pre_rst_ready", {31'b0, rdy16}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", {31'b0, rdy16}, 32'd1);
        check("arst_done", {31'b0, dn16}, 32'd0);
        check("arst_xout", xo16, 32'h0);
        check("arst_yout", yo16, 32'h0);
        check("arst_zout", zo16, 32'h0);
        check("arst_adda", aa16, 32'h0);
        check("arst_addb", ab16, 32'h0);
        check("arst_cin", {31'b0, ac16}, 32'd0);
        check("arst_idx", {27'b0, idx16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, 32'h26DD_3B6A, 32'h0, 32'h0C90_FDAA, lat, pulses, rdy_hi);
        check("post_rst_lat", lat, 32'd48);
        check("post_rst_pulses", pulses, 32'd1);
        check("post_rst_x", xo16, ex);
        check("post_rst_y", yo16, ey);

        // start held high: accepted every 3*N+2 = 5 edges.
        @(negedge clk);
        x_in = 32'h100; y_in = 32'h0; z_in = 32'h0;
        start1 = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_done_%0d", k), {31'b0, dn1},
                  {31'b0, (k % 5 == 3)});
        end
        start1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
